// File: rtl/vga_timing_pkg.sv
// Shared timing defaults for the VGA raster generator (640x480 @ 60 Hz,
// 25 MHz pixel rate) and the sync polarity encodings.
package vga_timing_pkg;

  localparam int CNT_W_DEF     = 10;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with enable, terminal-count flag and a
// registered sync output computed from the next count so it lines up with it.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int               CNT_W      = CNT_W_DEF,
  parameter logic [CNT_W-1:0] CNT_MAX    = '1,
  parameter logic [CNT_W-1:0] SYNC_START = '0,
  parameter logic [CNT_W-1:0] SYNC_END   = '0,
  parameter logic             SYNC_POL   = SYNC_ACTIVE_LOW
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_cnt_nxt,
  output logic             o_tc,
  output logic             o_sync
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sync;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_tc;
  logic             w_sync_nxt;

  assign w_tc = (r_cnt == CNT_MAX);

  // Next count: wrap at terminal count, otherwise step; hold when disabled.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_en) begin
      w_cnt_nxt = w_tc ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign w_sync_nxt = (w_cnt_nxt >= SYNC_START) && (w_cnt_nxt < SYNC_END);

  // Counter and sync register; reset parks the count at terminal so the
  // first enabled tick lands on zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= CNT_MAX;
      r_sync <= ~SYNC_POL;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_sync <= w_sync_nxt ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_cnt_nxt = w_cnt_nxt;
  assign o_tc      = w_tc;
  assign o_sync    = r_sync;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: hsync/vsync, display-valid, pixel coordinates
// and line/frame start pulses, advanced by a one-clock pixel tick.
// Optional macro VGA_FRAME_CNT_EN adds a 16-bit frames-since-reset counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE = H_VISIBLE_DEF,
  parameter int   H_FP      = H_FP_DEF,
  parameter int   H_SYNC    = H_SYNC_DEF,
  parameter int   H_BP      = H_BP_DEF,
  parameter int   V_VISIBLE = V_VISIBLE_DEF,
  parameter int   V_FP      = V_FP_DEF,
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BP      = V_BP_DEF,
  parameter logic SYNC_POL  = SYNC_ACTIVE_LOW,
  parameter int   CNT_W     = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pix_en,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic [CNT_W-1:0] o_v_cnt,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_valid,
  output logic             o_line_start,
  output logic             o_frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]      o_frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_MAX        = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_VIS_END    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_MAX        = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_VIS_END    = CNT_W'(V_VISIBLE);

  logic [CNT_W-1:0] w_h_nxt;
  logic [CNT_W-1:0] w_v_nxt;
  logic             w_h_tc;
  logic             w_v_tc;
  logic             w_v_en;
  logic             w_frame_wrap;
  logic             r_valid;
  logic             r_line_start;
  logic             r_frame_start;

  assign w_v_en       = i_pix_en & w_h_tc;
  assign w_frame_wrap = w_v_en & w_v_tc;

  vga_axis_counter #(
    .CNT_W      (CNT_W),
    .CNT_MAX    (H_MAX),
    .SYNC_START (H_SYNC_START),
    .SYNC_END   (H_SYNC_END),
    .SYNC_POL   (SYNC_POL)
  ) u_h_axis (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_en      (i_pix_en),
    .o_cnt     (o_h_cnt),
    .o_cnt_nxt (w_h_nxt),
    .o_tc      (w_h_tc),
    .o_sync    (o_hsync)
  );

  vga_axis_counter #(
    .CNT_W      (CNT_W),
    .CNT_MAX    (V_MAX),
    .SYNC_START (V_SYNC_START),
    .SYNC_END   (V_SYNC_END),
    .SYNC_POL   (SYNC_POL)
  ) u_v_axis (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_en      (w_v_en),
    .o_cnt     (o_v_cnt),
    .o_cnt_nxt (w_v_nxt),
    .o_tc      (w_v_tc),
    .o_sync    (o_vsync)
  );

  // Valid and start pulses registered from next-count state, aligned with the counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid       <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_valid       <= (w_h_nxt < H_VIS_END) && (w_v_nxt < V_VIS_END);
      r_line_start  <= w_v_en;
      r_frame_start <= w_frame_wrap;
    end
  end

  assign o_valid       = r_valid;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Frames started since reset; wraps naturally at 16 bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_cnt <= 16'd0;
    end else if (w_frame_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance for line-level timing and reset,
// and a tiny-raster instance (15x8, active-high sync) for whole-frame checks
// with a divide-by-4 pixel tick.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic d0_pix_en = 1'b0;
  logic s_pix_en = 1'b0;

  logic [9:0] d0_h_cnt, d0_v_cnt;
  logic       d0_hsync, d0_vsync, d0_valid, d0_ls, d0_fs;
  logic [3:0] s_h_cnt, s_v_cnt;
  logic       s_hsync, s_vsync, s_valid, s_ls, s_fs;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] d0_frame_cnt, s_frame_cnt;
`endif

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  vga_timing_gen d0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(d0_pix_en),
    .o_h_cnt(d0_h_cnt), .o_v_cnt(d0_v_cnt), .o_hsync(d0_hsync), .o_vsync(d0_vsync),
    .o_valid(d0_valid), .o_line_start(d0_ls), .o_frame_start(d0_fs)
`ifdef VGA_FRAME_CNT_EN
    , .o_frame_cnt(d0_frame_cnt)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .CNT_W(4)
  ) s (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(s_pix_en),
    .o_h_cnt(s_h_cnt), .o_v_cnt(s_v_cnt), .o_hsync(s_hsync), .o_vsync(s_vsync),
    .o_valid(s_valid), .o_line_start(s_ls), .o_frame_start(s_fs)
`ifdef VGA_FRAME_CNT_EN
    , .o_frame_cnt(s_frame_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int hs_low, vs_low, val_cnt, ls_cnt, first_low_h, found;
    int mh, mv, mism, fs_idx, last_fs_c, period, s_vs_hi, s_hs_hi, s_val;
    logic prev_en, exp_fs, exp_ls;

    // Reset state, both instances
    rst_n = 1'b0; d0_pix_en = 1'b1; s_pix_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_h", d0_h_cnt, 799);
    chk("rst_v", d0_v_cnt, 524);
    chk("rst_hsync", d0_hsync, 1);
    chk("rst_vsync", d0_vsync, 1);
    chk("rst_valid", d0_valid, 0);
    chk("rst_ls", d0_ls, 0);
    chk("rst_fs", d0_fs, 0);
    chk("rst_s_h", s_h_cnt, 14);
    chk("rst_s_v", s_v_cnt, 7);
    chk("rst_s_hsync", s_hsync, 0);
    chk("rst_s_vsync", s_vsync, 0);

    // Release with pix_en tied high: first tick, then one full line
    rst_n = 1'b1;
    hs_low = 0; vs_low = 0; val_cnt = 0; ls_cnt = 0; first_low_h = -1;
    for (int c = 1; c <= 800; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("first_h", d0_h_cnt, 0);
        chk("first_v", d0_v_cnt, 0);
        chk("first_valid", d0_valid, 1);
        chk("first_fs", d0_fs, 1);
        chk("first_ls", d0_ls, 1);
        chk("first_hsync", d0_hsync, 1);
        chk("first_vsync", d0_vsync, 1);
      end
      if (c == 2) begin
        chk("pulse_fs_1clk", d0_fs, 0);
        chk("pulse_ls_1clk", d0_ls, 0);
        chk("second_h", d0_h_cnt, 1);
      end
      if (c == 800) chk("line_last_h", d0_h_cnt, 799);
      if (!d0_hsync) begin
        if (first_low_h < 0) first_low_h = int'(d0_h_cnt);
        hs_low++;
      end
      if (!d0_vsync) vs_low++;
      if (d0_valid) val_cnt++;
      if (d0_ls) ls_cnt++;
    end
    chk("hsync_low_clks", hs_low, 96);
    chk("hsync_first_h", first_low_h, 656);
    chk("valid_clks_line", val_cnt, 640);
    chk("ls_per_line", ls_cnt, 1);
    chk("vsync_line0", vs_low, 0);
    @(negedge clk);
    chk("line1_ls", d0_ls, 1);
    chk("line1_h", d0_h_cnt, 0);
    chk("line1_v", d0_v_cnt, 1);
    chk("line1_fs", d0_fs, 0);

    // Reset mid-line at h=300
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      @(negedge clk);
      if (d0_h_cnt == 10'd300) found = 1;
    end
    chk("wait_h300", found, 1);
    chk("pre_rst_valid", d0_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_h", d0_h_cnt, 799);
    chk("midrst_v", d0_v_cnt, 524);
    chk("midrst_valid", d0_valid, 0);
    d0_pix_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_h", d0_h_cnt, 799);
    chk("hold_fs", d0_fs, 0);
    d0_pix_en = 1'b1;
    @(negedge clk);
    d0_pix_en = 1'b0;
    chk("after_rst_fs", d0_fs, 1);
    chk("after_rst_h", d0_h_cnt, 0);
    chk("after_rst_v", d0_v_cnt, 0);
    @(negedge clk);
    chk("idle_fs_low", d0_fs, 0);
    chk("idle_h_hold", d0_h_cnt, 0);

    // Tiny raster, pix_en every 4th clk: 15*8 ticks = 480 clks per frame
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    s_pix_en = 1'b0; prev_en = 1'b0;
    mh = 14; mv = 7; mism = 0; fs_idx = 0; last_fs_c = 0; period = 0;
    s_vs_hi = 0; s_hs_hi = 0; s_val = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      exp_fs = 1'b0; exp_ls = 1'b0;
      if (prev_en) begin
        if (mh == 14) begin
          exp_ls = 1'b1;
          mh = 0;
          if (mv == 7) begin mv = 0; exp_fs = 1'b1; end
          else mv++;
        end else mh++;
      end
      if (int'(s_h_cnt) != mh || int'(s_v_cnt) != mv || s_fs !== exp_fs || s_ls !== exp_ls)
        mism++;
      if (s_fs) begin
        fs_idx++;
        if (fs_idx == 2) period = c - last_fs_c;
        last_fs_c = c;
`ifdef VGA_FRAME_CNT_EN
        if (fs_idx <= 3) chk($sformatf("frame_cnt_%0d", fs_idx), s_frame_cnt, fs_idx);
`endif
      end
      if (fs_idx == 1) begin
        if (s_vsync) s_vs_hi++;
        if (s_hsync) s_hs_hi++;
        if (s_valid) s_val++;
      end
      s_pix_en = (c % 4 == 0);
      prev_en = s_pix_en;
    end
    chk("s_model_mismatches", mism, 0);
    chk("s_frames_seen", fs_idx, 4);
    chk("s_frame_period", period, 480);
    chk("s_vsync_clks", s_vs_hi, 120);
    chk("s_hsync_clks", s_hs_hi, 96);
    chk("s_valid_clks", s_val, 128);

`ifdef VGA_FRAME_CNT_EN
    force s.r_frame_cnt = 16'hFFFF;
    @(negedge clk);
    release s.r_frame_cnt;
    found = 0;
    for (int c = 0; c < 700 && found == 0; c++) begin
      s_pix_en = (c % 4 == 0);
      @(negedge clk);
      if (s_fs) found = 1;
    end
    chk("wrap_fs_seen", found, 1);
    chk("frame_cnt_wrap", s_frame_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
